// File: rtl/ap_unsi_wall_pipe_if.sv
// rtl/ap_unsi_wall_pipe_if.sv - operand/result handshake bundle for ap_unsi_wall_pipe
interface ap_unsi_wall_pipe_if #(
    parameter int DW    = 8,
    parameter int CNT_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     muld;
    logic [DW-1:0]     mulr;
    logic              apx_en;
    logic              out_valid;
    logic              out_ready;
    logic [2*DW-1:0]   res;
    logic              res_apx;
    logic [CNT_W-1:0]  err_cnt;

    modport master (
        output in_valid, muld, mulr, apx_en, out_ready,
        input  in_ready, out_valid, res, res_apx, err_cnt
    );

    modport slave (
        input  in_valid, muld, mulr, apx_en, out_ready,
        output in_ready, out_valid, res, res_apx, err_cnt
    );
endinterface

// File: rtl/ap_unsi_wall_pipe.sv
// rtl/ap_unsi_wall_pipe.sv - two-stage exact/approximate unsigned multiplier; AP_MULT_ERRCNT_EN enables the error counter
module ap_unsi_wall_pipe #(
    parameter int DW       = 8,
    parameter int APX_COLS = 3,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ap_unsi_wall_pipe_if.slave    bus
);
    localparam int NCOL = 2 * DW - 1;
    localparam int PW   = 2 * DW;
    localparam int PCW  = $clog2(DW + 1);

    logic adv;

    logic             v1_q;
    logic             apx1_q;
    logic [PCW-1:0]   col_d [NCOL];
    logic [PCW-1:0]   col_q [NCOL];

    logic             out_valid_q;
    logic             res_apx_q;
    logic [PW-1:0]    res_q;
    logic [PW-1:0]    res_d;

    logic [PW-1:0]    full_sum;
    logic [PW-1:0]    high_sum;
    logic [PW-1:0]    low_or;

    // Whole pipeline moves together; a stalled output freezes both stages.
    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.res       = res_q;
    assign bus.res_apx   = res_apx_q;

    // Column compression: popcount of every partial-product column.
    always_comb begin
        for (int k = 0; k < NCOL; k++) begin
            col_d[k] = '0;
        end
        for (int i = 0; i < DW; i++) begin
            for (int j = 0; j < DW; j++) begin
                col_d[i+j] = col_d[i+j] + PCW'(bus.muld[i] & bus.mulr[j]);
            end
        end
    end

    // Low columns collapse to an OR with no carry; high columns add exactly.
    always_comb begin
        full_sum = '0;
        high_sum = '0;
        low_or   = '0;
        for (int k = 0; k < NCOL; k++) begin
            full_sum = full_sum + (PW'(col_q[k]) << k);
            if (k >= APX_COLS) begin
                high_sum = high_sum + (PW'(col_q[k]) << k);
            end else begin
                low_or[k] = |col_q[k];
            end
        end
        res_d = apx1_q ? (high_sum | low_or) : full_sum;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            apx1_q      <= 1'b0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            res_apx_q   <= 1'b0;
            for (int k = 0; k < NCOL; k++) begin
                col_q[k] <= '0;
            end
        end else if (adv) begin
            v1_q        <= bus.in_valid;
            apx1_q      <= bus.apx_en;
            col_q       <= col_d;
            out_valid_q <= v1_q;
            res_q       <= res_d;
            res_apx_q   <= apx1_q;
        end
    end

`ifdef AP_MULT_ERRCNT_EN
    logic [DW-1:0]    muld1_q;
    logic [DW-1:0]    mulr1_q;
    logic [PW-1:0]    exact_q;
    logic [CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            muld1_q   <= '0;
            mulr1_q   <= '0;
            exact_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            if (adv) begin
                muld1_q <= bus.muld;
                mulr1_q <= bus.mulr;
                exact_q <= PW'(muld1_q) * PW'(mulr1_q);
            end
            if (out_valid_q && bus.out_ready && res_apx_q &&
                (res_q != exact_q) && (err_cnt_q != {CNT_W{1'b1}})) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = '0;
`endif
endmodule

// File: tb/tb_ap_unsi_wall_pipe.sv
// tb/tb_ap_unsi_wall_pipe.sv - directed self-checking bench for ap_unsi_wall_pipe (DW=8, APX_COLS=3, CNT_W=4)
module tb_ap_unsi_wall_pipe;
    localparam int DW    = 8;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;
    int   exp_err;

    ap_unsi_wall_pipe_if #(.DW(DW), .CNT_W(CNT_W)) bus ();

    ap_unsi_wall_pipe #(.DW(DW), .APX_COLS(3), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat_add(input int a, input int b);
        return (a + b > CMAX) ? CMAX : a + b;
    endfunction

    // One isolated transaction, checking latency, result and counter.
    task automatic do_one(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic apx, input int exp_res, input int exp_exact);
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.muld      = a;
        bus.mulr      = b;
        bus.apx_en    = apx;
        #1;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({tag, "_lat1_valid"}, 32'(bus.out_valid), 0);
        @(negedge clk);
        check({tag, "_valid"}, 32'(bus.out_valid), 1);
        check({tag, "_res"}, 32'(bus.res), exp_res);
        check({tag, "_res_apx"}, 32'(bus.res_apx), 32'(apx));
        @(negedge clk);
`ifdef AP_MULT_ERRCNT_EN
        if (apx && (exp_res != exp_exact)) exp_err = sat_add(exp_err, 1);
`endif
        check({tag, "_err_cnt"}, 32'(bus.err_cnt), exp_err);
        check({tag, "_drained"}, 32'(bus.out_valid), 0);
    endtask

    logic [7:0]  s_a   [8];
    logic [7:0]  s_b   [8];
    logic        s_apx [8];
    int          s_exp [8];

    initial begin
        int tx;
        int rx;
        int c;
        logic held;
        logic [15:0] held_res;

        n_checks = 0;
        n_err    = 0;
        exp_err  = 0;

        s_a[0] = 5;   s_b[0] = 5;   s_apx[0] = 1; s_exp[0] = 21;
        s_a[1] = 3;   s_b[1] = 3;   s_apx[1] = 1; s_exp[1] = 7;
        s_a[2] = 15;  s_b[2] = 15;  s_apx[2] = 1; s_exp[2] = 215;
        s_a[3] = 12;  s_b[3] = 10;  s_apx[3] = 0; s_exp[3] = 120;
        s_a[4] = 100; s_b[4] = 3;   s_apx[4] = 0; s_exp[4] = 300;
        s_a[5] = 9;   s_b[5] = 9;   s_apx[5] = 1; s_exp[5] = 81;
        s_a[6] = 200; s_b[6] = 200; s_apx[6] = 0; s_exp[6] = 40000;
        s_a[7] = 6;   s_b[7] = 6;   s_apx[7] = 1; s_exp[7] = 36;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.muld      = '0;
        bus.mulr      = '0;
        bus.apx_en    = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_res", 32'(bus.res), 0);
        check("rst_res_apx", 32'(bus.res_apx), 0);
        check("rst_err_cnt", 32'(bus.err_cnt), 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 1);

        do_one("apx_7x7", 8'd7, 8'd7, 1'b1, 39, 49);
        do_one("ex_7x7", 8'd7, 8'd7, 1'b0, 49, 49);
        do_one("apx_255x1", 8'd255, 8'd1, 1'b1, 255, 255);
        do_one("ex_255x255", 8'd255, 8'd255, 1'b0, 16'hFE01, 16'hFE01);

        // 2^CNT_W+5 erroneous approximate products back to back.
        for (int i = 0; i < CMAX + 1 + 5; i++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b1;
            bus.muld      = 8'd5;
            bus.mulr      = 8'd5;
            bus.apx_en    = 1'b1;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
`ifdef AP_MULT_ERRCNT_EN
        exp_err = sat_add(exp_err, CMAX + 1 + 5);
`endif
        check("sat_err_cnt", 32'(bus.err_cnt), exp_err);

        // Stream of 8 with out_ready low in cycles 3..5.
        tx = 0;
        rx = 0;
        c = 0;
        held = 1'b0;
        held_res = '0;
        while (rx < 8 && c < 40) begin
            @(negedge clk);
            bus.out_ready = !(c >= 3 && c <= 5);
            if (tx < 8) begin
                bus.in_valid = 1'b1;
                bus.muld     = s_a[tx];
                bus.mulr     = s_b[tx];
                bus.apx_en   = s_apx[tx];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.out_valid) begin
                if (held) check("stall_hold_res", 32'(bus.res), 32'(held_res));
                if (bus.out_ready) begin
                    check($sformatf("stream_res_%0d", rx), 32'(bus.res), s_exp[rx]);
                    check($sformatf("stream_apx_%0d", rx), 32'(bus.res_apx), 32'(s_apx[rx]));
                    rx++;
                    held = 1'b0;
                end else begin
                    check("stall_in_ready", 32'(bus.in_ready), 0);
                    held = 1'b1;
                    held_res = bus.res;
                end
            end
            if (bus.in_valid && bus.in_ready) tx++;
            c++;
        end
        check("stream_rx_count", 32'(rx), 8);
        check("stream_tx_count", 32'(tx), 8);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
`ifdef AP_MULT_ERRCNT_EN
        exp_err = sat_add(exp_err, 3);
`endif
        check("stream_err_cnt", 32'(bus.err_cnt), exp_err);
        check("stream_drained", 32'(bus.out_valid), 0);

        // One-cycle reset with two transactions in flight.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.muld     = 8'd7;
        bus.mulr     = 8'd7;
        bus.apx_en   = 1'b1;
        @(negedge clk);
        bus.muld     = 8'd3;
        bus.mulr     = 8'd3;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("pre_rst_valid", 32'(bus.out_valid), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        exp_err = 0;
        check("mid_rst_out_valid", 32'(bus.out_valid), 0);
        check("mid_rst_res", 32'(bus.res), 0);
        check("mid_rst_err_cnt", 32'(bus.err_cnt), 0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stale_valid", 32'(bus.out_valid), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
